tmds_channel_decoder: RTL

- Receive-side counterpart of the TMDS output lanes: decodes one TMDS channel from 10-bit parallel words into 8-bit pixel data, 2-bit control and a data-enable flag.
- Words arrive from the per-lane deserializer, which is word-aligned arbitrarily. The block finds symbol alignment itself by hunting for control tokens, with no bitslip feedback.
- Three instances, one per channel, sit in the video-input path in the pixel clock domain.

---
 rtl/tmds_pkg.sv | 23 ++
 rtl/tmds_symbol_decode.sv | 36 +++
 rtl/tmds_channel_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol/data widths, the four control tokens,
// the alignment state enum and a token-match helper.
package tmds_pkg;

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned DATA_W = 8;

    localparam logic [SYM_W-1:0] TOKEN_CTRL00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOKEN_CTRL01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOKEN_CTRL10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOKEN_CTRL11 = 10'b1010101011;

    typedef enum logic {
        HUNT,
        LOCKED
    } tmds_state_e;

    function automatic logic is_ctrl_token(input logic [SYM_W-1:0] sym);
        return (sym == TOKEN_CTRL00) || (sym == TOKEN_CTRL01) ||
               (sym == TOKEN_CTRL10) || (sym == TOKEN_CTRL11);
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: control-token match or 10b->8b data
// recovery (undo optional inversion, then undo the XOR/XNOR chain).
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0]  sym,
    output logic              is_token,
    output logic [1:0]        ctrl,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] t;

    // Token lookup first; any non-token word is treated as a data symbol
    always_comb begin
        is_token = 1'b1;
        ctrl     = '0;
        data     = '0;
        t        = '0;
        case (sym)
            TOKEN_CTRL00: ctrl = 2'b00;
            TOKEN_CTRL01: ctrl = 2'b01;
            TOKEN_CTRL10: ctrl = 2'b10;
            TOKEN_CTRL11: ctrl = 2'b11;
            default: begin
                is_token = 1'b0;
                t        = sym[9] ? ~sym[7:0] : sym[7:0];
                data[0]  = t[0];
                for (int unsigned i = 1; i < DATA_W; i++) begin
                    data[i] = sym[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: self-aligning word window, two-stage decode
// pipeline and HUNT/LOCKED alignment tracker.
// Optional lock statistics (lossCount, hunting) under TMDS_LOCK_STATS_EN.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 8,
    parameter int unsigned HUNT_DWELL   = 1024,
    parameter int unsigned LOSS_TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SYM_W-1:0]  symIn,
    input  logic              symValid,
    output logic [DATA_W-1:0] dataOut,
    output logic [1:0]        ctrlOut,
    output logic              deOut,
    output logic              validOut,
    output logic              locked,
    output logic [3:0]        offset
`ifdef TMDS_LOCK_STATS_EN
    ,
    output logic [7:0]        lossCount,
    output logic              hunting
`endif
);

    localparam int unsigned TOK_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned DWELL_W = $clog2(HUNT_DWELL);
    localparam int unsigned GAP_W   = $clog2(LOSS_TIMEOUT);

    localparam logic [TOK_W-1:0]   TOK_LAST   = TOK_W'(LOCK_COUNT - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HUNT_DWELL - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(LOSS_TIMEOUT - 1);
    localparam logic [3:0]         OFFSET_MAX = 4'(SYM_W - 1);

    // Alignment window and pipeline
    logic [SYM_W-1:0]  sym_prev_q, sym_prev_d;
    logic [SYM_W-1:0]  stage1_sym_q, stage1_sym_d;
    logic              stage1_vld_q, stage1_vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              de_q, de_d;
    logic              vld_q, vld_d;

    // Alignment tracker
    tmds_state_e       state_q, state_d;
    logic [3:0]        offset_q, offset_d;
    logic [TOK_W-1:0]  tok_run_q, tok_run_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic [SYM_W-1:0]  aligned;
    logic              aligned_is_tok;
    logic [3:0]        offset_inc;

    logic              dec_tok;
    logic [1:0]        dec_ctrl;
    logic [DATA_W-1:0] dec_data;

    tmds_symbol_decode u_decode (
        .sym      (stage1_sym_q),
        .is_token (dec_tok),
        .ctrl     (dec_ctrl),
        .data     (dec_data)
    );

    // Select the 10-bit symbol at the current offset from {current, previous}
    always_comb begin
        aligned        = SYM_W'({symIn, sym_prev_q} >> offset_q);
        aligned_is_tok = is_ctrl_token(aligned);
        offset_inc     = (offset_q == OFFSET_MAX) ? '0 : offset_q + 4'd1;
    end

    // Window capture, stage 1 (aligned word) and stage 2 (decoded fields)
    always_comb begin
        sym_prev_d   = sym_prev_q;
        stage1_sym_d = stage1_sym_q;
        if (symValid) begin
            sym_prev_d   = symIn;
            stage1_sym_d = aligned;
        end
        stage1_vld_d = symValid;
        vld_d        = stage1_vld_q;
        data_d       = data_q;
        ctrl_d       = ctrl_q;
        de_d         = de_q;
        if (stage1_vld_q) begin
            de_d   = ~dec_tok;
            data_d = dec_data;
            if (dec_tok) begin
                ctrl_d = dec_ctrl;
            end
        end
    end

    // Next-state logic: token-run lock search in HUNT, token-gap watchdog in LOCKED
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        tok_run_d = tok_run_q;
        dwell_d   = dwell_q;
        gap_d     = gap_q;
        if (symValid) begin
            case (state_q)
                HUNT: begin
                    // Lock takes priority over a coincident dwell expiry
                    if (aligned_is_tok && (tok_run_q == TOK_LAST)) begin
                        state_d   = LOCKED;
                        tok_run_d = '0;
                        dwell_d   = '0;
                        gap_d     = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        offset_d  = offset_inc;
                        dwell_d   = '0;
                        tok_run_d = '0;
                    end else begin
                        dwell_d   = dwell_q + 1'b1;
                        tok_run_d = aligned_is_tok ? tok_run_q + 1'b1 : '0;
                    end
                end
                LOCKED: begin
                    if (aligned_is_tok) begin
                        gap_d = '0;
                    end else if (gap_q == GAP_LAST) begin
                        state_d   = HUNT;
                        offset_d  = offset_inc;
                        gap_d     = '0;
                        tok_run_d = '0;
                        dwell_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State register and pipeline flops; reset flushes everything
    always_ff @(posedge clock) begin
        if (reset) begin
            sym_prev_q   <= '0;
            stage1_sym_q <= '0;
            stage1_vld_q <= 1'b0;
            data_q       <= '0;
            ctrl_q       <= '0;
            de_q         <= 1'b0;
            vld_q        <= 1'b0;
            state_q      <= HUNT;
            offset_q     <= '0;
            tok_run_q    <= '0;
            dwell_q      <= '0;
            gap_q        <= '0;
        end else begin
            sym_prev_q   <= sym_prev_d;
            stage1_sym_q <= stage1_sym_d;
            stage1_vld_q <= stage1_vld_d;
            data_q       <= data_d;
            ctrl_q       <= ctrl_d;
            de_q         <= de_d;
            vld_q        <= vld_d;
            state_q      <= state_d;
            offset_q     <= offset_d;
            tok_run_q    <= tok_run_d;
            dwell_q      <= dwell_d;
            gap_q        <= gap_d;
        end
    end

    // Output drive from registered state
    always_comb begin
        dataOut  = data_q;
        ctrlOut  = ctrl_q;
        deOut    = de_q;
        validOut = vld_q;
        locked   = (state_q == LOCKED);
        offset   = offset_q;
    end

`ifdef TMDS_LOCK_STATS_EN
    logic       lose_lock;
    logic [7:0] loss_count_q, loss_count_d;

    // Saturating count of LOCKED->HUNT transitions
    always_comb begin
        lose_lock    = symValid && (state_q == LOCKED) && !aligned_is_tok &&
                       (gap_q == GAP_LAST);
        loss_count_d = loss_count_q;
        if (lose_lock && (loss_count_q != '1)) begin
            loss_count_d = loss_count_q + 8'd1;
        end
    end

    // Statistics register
    always_ff @(posedge clock) begin
        if (reset) begin
            loss_count_q <= '0;
        end else begin
            loss_count_q <= loss_count_d;
        end
    end

    // Statistics outputs
    always_comb begin
        lossCount = loss_count_q;
        hunting   = (state_q == HUNT);
    end
`else
    // Statistics disabled: no extra ports or counters
`endif

endmodule
